// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Bundles the value input and the display/BCD outputs of seg7_scan_display.
//   master : the count source / observer (drives value, reads the outputs)
//   slave  : the display block itself
//   Signals:
//     value [7:0]  unsigned binary value to convert and show
//     an    [3:0]  digit enables, active-low, an[0] = ones digit
//     seg   [6:0]  segments gfedcba, active-low
//     dp           decimal point, active-low (always off)
//     bcd   [11:0] {hundreds, tens, ones} of the last completed conversion
//     upd          one-cycle pulse when bcd and the display digits update
interface seg7_scan_display_if;
   logic [7:0]  value;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [11:0] bcd;
   logic        upd;

   modport master (output value, input an, seg, dp, bcd, upd);
   modport slave  (input value, output an, seg, dp, bcd, upd);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Converts an 8-bit value to three BCD digits with a sequential
//   shift-add-3 engine (10 cycles per conversion, running continuously) and
//   scans the result onto a 4-digit common-anode 7-segment display.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    seg7_scan_display_if.slave (value in; an/seg/dp/bcd/upd out)
//   Parameter:
//     REFRESH_DIV  clk cycles each digit stays lit (2..65535)
module seg7_scan_display #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                       clk,
   input  logic                       reset,
   seg7_scan_display_if.slave         bus
);

   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
   localparam logic [6:0]  SEG_BLANK    = 7'b1111111;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t      state_q,   state_d;
   logic [7:0]  shift_q,   shift_d;
   logic [11:0] acc_q,     acc_d;
   logic [2:0]  iter_q,    iter_d;
   logic [11:0] bcd_q,     bcd_d;
   logic        upd_q,     upd_d;
   logic [11:0] disp_q,    disp_d;
   logic [15:0] refresh_q, refresh_d;
   logic [1:0]  idx_q,     idx_d;
   logic [3:0]  an_q,      an_d;
   logic [6:0]  seg_q,     seg_d;

   // Add-3 correction applied to every nibble of the accumulator before the
   // shift, so a nibble that would reach 10+ after doubling carries instead.
   logic [11:0] acc_adj;
   for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                  acc_q[4*gi +: 4] + 4'd3 : acc_q[4*gi +: 4];
   end

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_encode = 7'b1000000;
         4'd1:    seg_encode = 7'b1111001;
         4'd2:    seg_encode = 7'b0100100;
         4'd3:    seg_encode = 7'b0110000;
         4'd4:    seg_encode = 7'b0011001;
         4'd5:    seg_encode = 7'b0010010;
         4'd6:    seg_encode = 7'b0000010;
         4'd7:    seg_encode = 7'b1111000;
         4'd8:    seg_encode = 7'b0000000;
         4'd9:    seg_encode = 7'b0010000;
         default: seg_encode = SEG_BLANK;
      endcase
   endfunction

   // Conversion FSM
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      iter_d  = iter_q;
      bcd_d   = bcd_q;
      disp_d  = disp_q;
      upd_d   = 1'b0;
      case (state_q)
         IDLE: begin
            shift_d = bus.value;
            acc_d   = '0;
            iter_d  = '0;
            state_d = CONV;
         end
         CONV: begin
            {acc_d, shift_d} = {acc_adj[10:0], shift_q, 1'b0};
            iter_d           = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            bcd_d   = acc_q;
            disp_d  = acc_q;
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan: digit index advances when the refresh counter wraps; an/seg are
   // registered from the index as it stands before the edge.
   always_comb begin
      refresh_d = refresh_q + 16'd1;
      idx_d     = idx_q;
      if (refresh_q == REFRESH_LAST) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end

      an_d = ~(4'b0001 << idx_q);
      case (idx_q)
         2'd0:    seg_d = seg_encode(disp_q[3:0]);
         2'd1:    seg_d = (disp_q[11:4] == 8'd0) ? SEG_BLANK : seg_encode(disp_q[7:4]);
         2'd2:    seg_d = (disp_q[11:8] == 4'd0) ? SEG_BLANK : seg_encode(disp_q[11:8]);
         default: seg_d = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         acc_q     <= '0;
         iter_q    <= '0;
         bcd_q     <= '0;
         upd_q     <= 1'b0;
         disp_q    <= '0;
         refresh_q <= '0;
         idx_q     <= '0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         acc_q     <= acc_d;
         iter_q    <= iter_d;
         bcd_q     <= bcd_d;
         upd_q     <= upd_d;
         disp_q    <= disp_d;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = 1'b1;
   assign bus.bcd = bcd_q;
   assign bus.upd = upd_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

   localparam int D = 4;

   logic clk;
   logic reset;

   seg7_scan_display_if bus();

   seg7_scan_display #(.REFRESH_DIV(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state, expressed in decimal terms
   int n;          // edges since reset release (E-number of the next edge)
   int cap;        // value captured at the last capture edge
   int disp;       // decimal value currently held by the display digits
   logic [11:0] bcd_exp;
   logic        upd_exp;

   logic [6:0] seg_tab [10];
   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
      seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
      seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
      seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
   end

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   function automatic logic [6:0] seg_of(input int d, input int idx);
      case (idx)
         0:       return seg_tab[d % 10];
         1:       return (d < 10)  ? 7'b1111111 : seg_tab[(d / 10) % 10];
         2:       return (d < 100) ? 7'b1111111 : seg_tab[d / 100];
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (E%0d)", tag, obs, expv, n);
      end
   endtask

   // One clock edge with full output check against the model
   task automatic step();
      int idx;
      int old_disp;
      idx      = (n / D) % 4;
      old_disp = disp;
      if (n % 10 == 0) cap = int'(bus.value);
      @(posedge clk);
      #1;
      upd_exp = (n % 10 == 9);
      if (n % 10 == 9) begin
         disp    = cap;
         bcd_exp = to_bcd(cap);
      end
      chk("an",  {8'd0, bus.an},  {8'd0, ~(4'b0001 << idx)});
      chk("seg", {5'd0, bus.seg}, {5'd0, seg_of(old_disp, idx)});
      chk("dp",  {11'd0, bus.dp}, 12'd1);
      chk("upd", {11'd0, bus.upd}, {11'd0, upd_exp});
      chk("bcd", bus.bcd, bcd_exp);
      n++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_an",  {8'd0, bus.an},  12'h00F);
      chk("rst_seg", {5'd0, bus.seg}, 12'h07F);
      chk("rst_dp",  {11'd0, bus.dp}, 12'd1);
      chk("rst_upd", {11'd0, bus.upd}, 12'd0);
      chk("rst_bcd", bus.bcd, 12'h000);
      reset   = 1'b0;
      n       = 0;
      cap     = 0;
      disp    = 0;
      bcd_exp = 12'h000;
      upd_exp = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      bus.value = 8'd0;
      n = 0; cap = 0; disp = 0; bcd_exp = '0; upd_exp = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // value 0: first upd after E9, blank digits 1..3 scanned in turn
      do_reset();
      repeat (40) step();

      bus.value = 8'd255;
      repeat (30) step();
      chk("bcd_255", bus.bcd, 12'h255);

      bus.value = 8'd7;
      repeat (30) step();
      chk("bcd_7", bus.bcd, 12'h007);

      bus.value = 8'd40;
      repeat (30) step();
      chk("bcd_40", bus.bcd, 12'h040);

      // value changes mid-conversion are ignored until the next capture
      bus.value = 8'd100;
      do_reset();
      repeat (4) step();
      bus.value = 8'd99;
      repeat (6) step();
      chk("bcd_100", bus.bcd, 12'h100);
      repeat (10) step();
      chk("bcd_99", bus.bcd, 12'h099);
      repeat (10) step();

      // reset at E5 aborts the conversion
      bus.value = 8'd200;
      do_reset();
      repeat (5) step();
      do_reset();
      repeat (10) step();
      chk("bcd_200", bus.bcd, 12'h200);

      // random values changing every cycle
      repeat (200) begin
         bus.value = 8'($urandom);
         step();
      end

      // exhaustive sweep, one value per conversion period
      do_reset();
      for (int v = 0; v < 256; v++) begin
         bus.value = 8'(v);
         repeat (10) step();
         chk("sweep_bcd", bus.bcd, to_bcd(v));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
